// File: rtl/data_m_pkg.sv
// ============================================================================
// data_m_pkg : shared types and constants for the data_m bus initiator
// Revision   : 1.0
// ============================================================================
`default_nettype none

package data_m_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } data_m_init_state_t;

  localparam int DATA_M_WIDTH         = 16;
  localparam int DATA_M_BYTESEL_WIDTH = 2;

  localparam logic [DATA_M_WIDTH-1:0] DATA_M_TIMEOUT_DATA = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/data_m_timeout_counter.sv
// ============================================================================
// data_m_timeout_counter : counts ACCESS cycles without ack, flags expiry
// Revision               : 1.0
// ============================================================================
`default_nettype none

module data_m_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != C_TERMINAL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds completed no-ack cycles; this cycle makes it TIMEOUT_CYCLES.
  assign expired = enable && (r_count == C_TERMINAL);

endmodule

`default_nettype wire

// File: rtl/data_m_initiator.sv
// ============================================================================
// data_m_initiator : single-outstanding data_m bus master (cmd -> bus -> rsp)
// Optional access timeout enabled by defining DATA_M_TIMEOUT_EN.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module data_m_initiator
  import data_m_pkg::*;
#(
  parameter int ADDR_WIDTH     = 19,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_wr,
  input  logic [ADDR_WIDTH-1:0]           cmd_addr,
  input  logic [DATA_M_WIDTH-1:0]         cmd_data,
  input  logic [DATA_M_BYTESEL_WIDTH-1:0] cmd_bytesel,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_M_WIDTH-1:0]         rsp_data,
  output logic                            rsp_error,
  output logic [ADDR_WIDTH-1:0]           data_m_addr,
  output logic [DATA_M_WIDTH-1:0]         data_m_data_out,
  output logic [DATA_M_BYTESEL_WIDTH-1:0] data_m_bytesel,
  output logic                            data_m_wr_en,
  output logic                            data_m_access,
  input  logic [DATA_M_WIDTH-1:0]         data_m_data_in,
  input  logic                            data_m_ack
);

  data_m_init_state_t r_state, w_state_next;

  logic                            r_cmd_ready, w_cmd_ready;
  logic [ADDR_WIDTH-1:0]           r_addr, w_addr;
  logic [DATA_M_WIDTH-1:0]         r_wdata, w_wdata;
  logic [DATA_M_BYTESEL_WIDTH-1:0] r_bytesel, w_bytesel;
  logic                            r_wr_en, w_wr_en;
  logic                            r_access, w_access;
  logic                            r_rsp_valid, w_rsp_valid;
  logic [DATA_M_WIDTH-1:0]         r_rsp_data, w_rsp_data;
  logic                            r_rsp_error, w_rsp_error;

  logic w_cmd_fire;
  logic w_expired;

  assign w_cmd_fire = cmd_valid && r_cmd_ready;

`ifdef DATA_M_TIMEOUT_EN
  data_m_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_cmd_fire),
    .enable  ((r_state == ACCESS) && !data_m_ack),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_bytesel    = r_bytesel;
    w_wr_en      = r_wr_en;
    w_access     = r_access;
    w_rsp_valid  = r_rsp_valid;
    w_rsp_data   = r_rsp_data;
    w_rsp_error  = r_rsp_error;

    case (r_state)
      IDLE: begin
        if (w_cmd_fire) begin
          w_addr       = cmd_addr;
          w_wdata      = cmd_wr ? cmd_data : '0;
          w_bytesel    = cmd_bytesel;
          w_wr_en      = cmd_wr;
          w_access     = 1'b1;
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        // Ack has priority over a coincident timeout.
        if (data_m_ack) begin
          w_rsp_data   = r_wr_en ? '0 : data_m_data_in;
          w_rsp_error  = 1'b0;
          w_rsp_valid  = 1'b1;
          w_access     = 1'b0;
          w_wr_en      = 1'b0;
          w_state_next = RESPOND;
        end else if (w_expired) begin
          w_rsp_data   = DATA_M_TIMEOUT_DATA;
          w_rsp_error  = 1'b1;
          w_rsp_valid  = 1'b1;
          w_access     = 1'b0;
          w_wr_en      = 1'b0;
          w_state_next = RESPOND;
        end
      end
      RESPOND: begin
        // The responder's trailing ack lands here and is deliberately ignored.
        if (rsp_ready) begin
          w_rsp_valid  = 1'b0;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_cmd_ready = (w_state_next == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_ready <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_bytesel   <= '0;
      r_wr_en     <= 1'b0;
      r_access    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_cmd_ready <= w_cmd_ready;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_bytesel   <= w_bytesel;
      r_wr_en     <= w_wr_en;
      r_access    <= w_access;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_data  <= w_rsp_data;
      r_rsp_error <= w_rsp_error;
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign rsp_error       = r_rsp_error;
  assign data_m_addr     = r_addr;
  assign data_m_data_out = r_wdata;
  assign data_m_bytesel  = r_bytesel;
  assign data_m_wr_en    = r_wr_en;
  assign data_m_access   = r_access;

endmodule

`default_nettype wire

// File: tb/tb_data_m_initiator.sv
// ============================================================================
// tb_data_m_initiator : directed self-checking bench for data_m_initiator
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_data_m_initiator;

  localparam int ADDR_WIDTH = 19;

  logic                  clk;
  logic                  reset_n;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [15:0]           cmd_data;
  logic [1:0]            cmd_bytesel;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [15:0]           rsp_data;
  logic                  rsp_error;
  logic [ADDR_WIDTH-1:0] data_m_addr;
  logic [15:0]           data_m_data_out;
  logic [1:0]            data_m_bytesel;
  logic                  data_m_wr_en;
  logic                  data_m_access;
  logic [15:0]           data_m_data_in;
  logic                  data_m_ack;

  logic        resp_en;
  logic [15:0] resp_value;

  int checks   = 0;
  int failures = 0;

  data_m_initiator #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_wr          (cmd_wr),
    .cmd_addr        (cmd_addr),
    .cmd_data        (cmd_data),
    .cmd_bytesel     (cmd_bytesel),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_error       (rsp_error),
    .data_m_addr     (data_m_addr),
    .data_m_data_out (data_m_data_out),
    .data_m_bytesel  (data_m_bytesel),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_access   (data_m_access),
    .data_m_data_in  (data_m_data_in),
    .data_m_ack      (data_m_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered responder: acks every cycle it sees access, one cycle late.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_m_ack     <= 1'b0;
      data_m_data_in <= 16'h0000;
    end else if (data_m_access && resp_en) begin
      data_m_ack     <= 1'b1;
      data_m_data_in <= resp_value;
    end else begin
      data_m_ack     <= 1'b0;
      data_m_data_in <= 16'h0000;
    end
  end

  task automatic do_cmd(input logic wr, input logic [ADDR_WIDTH-1:0] addr,
                        input logic [15:0] data, input logic [1:0] bsel);
    int t;
    cmd_wr      = wr;
    cmd_addr    = addr;
    cmd_data    = data;
    cmd_bytesel = bsel;
    cmd_valid   = 1'b1;
    t = 0;
    while (!cmd_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 20) begin
      failures++;
      $display("FAIL cmd_handshake: cmd_ready never rose within %0d cycles", t);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_error, data_m_addr, data_m_data_out,
         data_m_bytesel, data_m_wr_en, data_m_access} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got cmd_ready=%b rsp_valid=%b rsp_data=%h access=%b addr=%h, want all 0",
               cmd_ready, rsp_valid, rsp_data, data_m_access, data_m_addr);
    end
    #3 reset_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_clock: got %b want 0", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_release: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_read();
    int lat, acc;
    resp_en    = 1'b1;
    resp_value = 16'h0001;
    rsp_ready  = 1'b0;
    do_cmd(1'b0, 19'h00010, 16'hDEAD, 2'b11);
    checks++;
    if ({data_m_access, data_m_wr_en, data_m_addr, data_m_data_out} !== {1'b1, 1'b0, 19'h00010, 16'h0000}) begin
      failures++;
      $display("FAIL read_bus: got access=%b wr=%b addr=%h dout=%h want 1 0 00010 0000",
               data_m_access, data_m_wr_en, data_m_addr, data_m_data_out);
    end
    lat = 1;
    acc = 0;
    while (!rsp_valid && lat < 20) begin
      if (data_m_access) acc++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL read_latency: got %0d want 3", lat);
    end
    checks++;
    if (acc != 2) begin
      failures++;
      $display("FAIL read_access_len: got %0d want 2", acc);
    end
    checks++;
    if ({rsp_data, rsp_error, data_m_access, cmd_ready} !== {16'h0001, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL read_rsp: got data=%h err=%b access=%b ready=%b want 0001 0 0 0",
               rsp_data, rsp_error, data_m_access, cmd_ready);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL read_release: got valid=%b ready=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_write();
    int lat, bad;
    resp_en    = 1'b1;
    resp_value = 16'h7777;
    rsp_ready  = 1'b0;
    do_cmd(1'b1, 19'h01234, 16'hA55A, 2'b11);
    lat = 1;
    bad = 0;
    while (!rsp_valid && lat < 20) begin
      if ({data_m_access, data_m_wr_en, data_m_addr, data_m_data_out, data_m_bytesel} !==
          {1'b1, 1'b1, 19'h01234, 16'hA55A, 2'b11}) bad++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (bad != 0 || lat != 3) begin
      failures++;
      $display("FAIL write_bus_stable: got %0d bad cycles latency %0d want 0 and 3", bad, lat);
    end
    checks++;
    if ({rsp_data, rsp_error, data_m_wr_en, data_m_access} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL write_rsp: got data=%h err=%b wr=%b access=%b want 0000 0 0 0",
               rsp_data, rsp_error, data_m_wr_en, data_m_access);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nrsp, last, run, overlap;
    resp_en    = 1'b1;
    resp_value = 16'h1357;
    cmd_wr     = 1'b0;
    cmd_addr   = 19'h00020;
    rsp_ready  = 1'b1;
    cmd_valid  = 1'b1;
    nrsp = 0; last = -1; run = 0; overlap = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (cmd_ready && rsp_valid) overlap++;
      if (rsp_valid) begin
        nrsp++;
        checks++;
        if (rsp_data !== 16'h1357) begin
          failures++;
          $display("FAIL b2b_data: got %h want 1357", rsp_data);
        end
        if (last < 0) begin
          checks++;
          if (i != 3) begin
            failures++;
            $display("FAIL b2b_first_rsp: got cycle %0d want 3", i);
          end
        end else begin
          checks++;
          if (i - last != 4) begin
            failures++;
            $display("FAIL b2b_period: got %0d want 4", i - last);
          end
        end
        last = i;
      end
      if (data_m_access) begin
        run++;
      end else if (run > 0) begin
        checks++;
        if (run != 2) begin
          failures++;
          $display("FAIL b2b_access_len: got %0d want 2", run);
        end
        run = 0;
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (nrsp != 4 || overlap != 0) begin
      failures++;
      $display("FAIL b2b_count: got %0d responses %0d overlaps want 4 and 0", nrsp, overlap);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int t;
    resp_en    = 1'b1;
    resp_value = 16'hBEEF;
    rsp_ready  = 1'b0;
    do_cmd(1'b0, 19'h00040, 16'h0000, 2'b01);
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (!rsp_valid) begin
      failures++;
      $display("FAIL bp_rsp: rsp_valid %b want 1", rsp_valid);
    end
    cmd_wr    = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_data, cmd_ready, data_m_access} !== {1'b1, 16'hBEEF, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b access=%b want 1 beef 0 0",
                 i, rsp_valid, rsp_data, cmd_ready, data_m_access);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, data_m_access} !== 2'b00) begin
      failures++;
      $display("FAIL bp_release: got valid=%b access=%b want 0 0", rsp_valid, data_m_access);
    end
  endtask

`ifdef DATA_M_TIMEOUT_EN
  task automatic test_timeout();
    int lat, acc;
    resp_en   = 1'b0;
    rsp_ready = 1'b0;
    do_cmd(1'b0, 19'h00080, 16'h0000, 2'b11);
    lat = 1;
    acc = 0;
    while (!rsp_valid && lat < 40) begin
      if (data_m_access) acc++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (acc != 8) begin
      failures++;
      $display("FAIL timeout_access_len: got %0d want 8", acc);
    end
    checks++;
    if ({rsp_valid, rsp_data, rsp_error, data_m_access} !== {1'b1, 16'hFFFF, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL timeout_rsp: got valid=%b data=%h err=%b access=%b want 1 ffff 1 0",
               rsp_valid, rsp_data, rsp_error, data_m_access);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    int seen;
    resp_en   = 1'b0;
    rsp_ready = 1'b1;
    do_cmd(1'b1, 19'h05555, 16'h3C3C, 2'b10);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_error, data_m_addr, data_m_data_out,
         data_m_bytesel, data_m_wr_en, data_m_access} !== '0) begin
      failures++;
      $display("FAIL midreset_async: got access=%b wr=%b addr=%h dout=%h bsel=%b, want all 0",
               data_m_access, data_m_wr_en, data_m_addr, data_m_data_out, data_m_bytesel);
    end
    #2 reset_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_ready_early: got %b want 0", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready: got %b want 1", cmd_ready);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || data_m_access) seen++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midreset_no_rsp: got %0d active cycles want 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_wr      = 1'b0;
    cmd_addr    = '0;
    cmd_data    = 16'h0000;
    cmd_bytesel = 2'b00;
    rsp_ready   = 1'b0;
    resp_en     = 1'b1;
    resp_value  = 16'h0000;

    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_backpressure();
`ifdef DATA_M_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
